// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the fetch stage and the central control unit:
//   - enable-vector bit indices for inst_en (central drives the same vector)
//   - bit positions of the IR fields
//   - fetch FSM state encoding
package fetch_unit_pkg;

    // Bit positions inside the six-bit enable vector {PC, INST, ADDR, Y, OP, X}
    localparam int PC_EN   = 5;
    localparam int INST_EN = 4;
    localparam int ADDR_EN = 3;
    localparam int Y_EN    = 2;
    localparam int OP_EN   = 1;
    localparam int X_EN    = 0;

    // Instruction field positions for a 16-bit instruction word
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int X_MSB    = 12;
    localparam int X_LSB    = 10;
    localparam int Y_MSB    = 9;
    localparam int Y_LSB    = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc
// Program counter register. A load takes priority over an increment; the
// increment wraps modulo 2^ADDR_W.
// Ports:
//   clk    in   clock
//   clr    in   synchronous active-high reset (PC -> 0)
//   load   in   load PC from target
//   inc    in   increment PC
//   target in   load value
//   pc     out  program counter
module fetch_pc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch and field-decode stage. Owns the PC, runs a req/ack read
// against instruction memory, captures the word in the IR and splits the IR
// into op / x / y / addr field registers under control of inst_en.
// Optional feature macro: FETCH_TIMEOUT_EN (abort a fetch after TIMEOUT
// cycles without mem_ack, raising fetch_err together with fetch_done).
// Ports:
//   clk, clr          clock, synchronous active-high reset
//   en_fetch          fetch start strobe (only honoured in IDLE)
//   inst_en[5:0]      {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}
//   pc_load/pc_target jump request and destination
//   mem_req/mem_addr  memory read request and address (= pc)
//   mem_ack/mem_rdata memory read valid and data
//   busy, fetch_done, fetch_err   status
//   op_q, x_sel, y_sel, addr_q    decoded field registers
//   pc                program counter
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int INST_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en_fetch,
    input  logic [5:0]        inst_en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [2:0]        op_q,
    output logic [2:0]        x_sel,
    output logic [1:0]        y_sel,
    output logic [7:0]        addr_q,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [INST_W-1:0] ir;
    logic              timeout_hit;
    logic              complete;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              pc_ld;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_tgt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        busy       = 1'b0;
        fetch_done = 1'b0;
        case (state)
            IDLE: begin
                if (en_fetch) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                fetch_done = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A fetch ends either with the memory acknowledge or with a timeout abort.
    assign complete = (state == REQ) && (mem_ack || timeout_hit);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT)) && !mem_ack;

    // Wait counter restarts when a fetch is launched and counts unacked cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt <= '0;
        end else if (state == IDLE && en_fetch) begin
            wait_cnt <= '0;
        end else if (state == REQ && !mem_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == REQ) && timeout_hit;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout_hit = 1'b0;
    // No abort path exists, so this is constant low for any sensible TIMEOUT.
    assign fetch_err   = (TIMEOUT < 0);
`endif

    // A jump requested while the request is outstanding is parked here so the
    // address seen by memory cannot change under an active mem_req.
    always_ff @(posedge clk) begin
        if (clr) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (state == REQ && pc_load && !complete) begin
            pend_valid  <= 1'b1;
            pend_target <= pc_target;
        end else if (complete) begin
            pend_valid  <= 1'b0;
        end
    end

    assign pc_ld  = (pc_load && state != REQ) || (complete && (pc_load || pend_valid));
    assign pc_tgt = pc_load ? pc_target : pend_target;
    assign pc_inc = (state == REQ) && mem_ack && inst_en[PC_EN];

    fetch_pc #(
        .ADDR_W (ADDR_W)
    ) u_fetch_pc (
        .clk    (clk),
        .clr    (clr),
        .load   (pc_ld),
        .inc    (pc_inc),
        .target (pc_tgt),
        .pc     (pc)
    );

    assign mem_addr = pc;

    // IR captures the memory word on ack, or becomes a NOP on a timeout abort.
    always_ff @(posedge clk) begin
        if (clr) begin
            ir <= '0;
        end else if (state == REQ && inst_en[INST_EN]) begin
            if (mem_ack) begin
                ir <= mem_rdata;
            end else if (timeout_hit) begin
                ir <= '0;
            end
        end
    end

    // Field registers sample the current IR whenever their enable is set.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_q   <= '0;
            x_sel  <= '0;
            y_sel  <= '0;
            addr_q <= '0;
        end else begin
            if (inst_en[OP_EN]) begin
                op_q <= ir[OP_MSB:OP_LSB];
            end
            if (inst_en[X_EN]) begin
                x_sel <= ir[X_MSB:X_LSB];
            end
            if (inst_en[Y_EN]) begin
                y_sel <= ir[Y_MSB:Y_LSB];
            end
            if (inst_en[ADDR_EN]) begin
                addr_q <= ir[ADDR_MSB:ADDR_LSB];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetches compared against a transaction-level model of PC and IR.
// Honours FETCH_TIMEOUT_EN for the no-acknowledge scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        en_fetch;
    logic [5:0]  inst_en;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;
    logic [2:0]  op_q;
    logic [2:0]  x_sel;
    logic [1:0]  y_sel;
    logic [7:0]  addr_q;
    logic [7:0]  pc;

    int testCount = 0;
    int failCount = 0;

    // Reference state: what PC and IR should hold after each transaction
    logic [7:0]  expPc;
    logic [15:0] expIr;

    always #5 clk = ~clk;

    fetch_unit #(
        .INST_W  (16),
        .ADDR_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .en_fetch   (en_fetch),
        .inst_en    (inst_en),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .op_q       (op_q),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .addr_q     (addr_q),
        .pc         (pc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset;
        clr       = 1'b1;
        en_fetch  = 1'b0;
        inst_en   = '0;
        pc_load   = 1'b0;
        pc_target = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick;
        tick;
        clr   = 1'b0;
        expPc = '0;
        expIr = '0;
    endtask

    // Pulse all field enables and compare against the model's IR split
    task automatic checkFields;
        inst_en = 6'b001111;
        tick;
        inst_en = '0;
        checkOutput("op_q",   32'(op_q),   32'((expIr >> 13) & 16'h7));
        checkOutput("x_sel",  32'(x_sel),  32'((expIr >> 10) & 16'h7));
        checkOutput("y_sel",  32'(y_sel),  32'((expIr >> 8) & 16'h3));
        checkOutput("addr_q", 32'(addr_q), 32'(expIr % 256));
    endtask

    task automatic idleJump(input logic [7:0] tgt);
        pc_load   = 1'b1;
        pc_target = tgt;
        tick;
        pc_load = 1'b0;
        expPc   = tgt;
        checkOutput("pc_jump", 32'(pc), 32'(expPc));
    endtask

    // One complete fetch: enHi = {PC_EN, INST_EN}, waits = unacked REQ cycles,
    // optional jump mid-request and/or on the completion edge, optional extra
    // strobes that must be ignored.
    task automatic applyStimulus(input logic [1:0] enHi, input int waits, input logic [15:0] data,
                                 input bit midLoad, input logic [7:0] midTgt,
                                 input bit endLoad, input logic [7:0] endTgt, input bit extraStrobe);
        int         reqCycles;
        logic [7:0] pcBefore;
        pcBefore = expPc;
        inst_en  = {enHi, 4'b0000};
        en_fetch = 1'b1;
        tick;
        en_fetch  = 1'b0;
        reqCycles = 0;
        checkOutput("busy_start", 32'(busy), 32'd1);
        checkOutput("addr_start", 32'(mem_addr), 32'(pcBefore));
        if (mem_req) reqCycles++;
        for (int i = 0; i < waits; i++) begin
            if (i == 0 && midLoad) begin
                pc_load   = 1'b1;
                pc_target = midTgt;
            end
            en_fetch = extraStrobe;
            tick;
            pc_load  = 1'b0;
            en_fetch = 1'b0;
            if (mem_req) reqCycles++;
            checkOutput("addr_stable", 32'(mem_addr), 32'(pcBefore));
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        if (endLoad) begin
            pc_load   = 1'b1;
            pc_target = endTgt;
        end
        tick;
        mem_ack = 1'b0;
        pc_load = 1'b0;
        if (enHi[0]) expIr = data;
        if (endLoad) expPc = endTgt;
        else if (midLoad && waits > 0) expPc = midTgt;
        else if (enHi[1]) expPc = expPc + 8'd1;
        checkOutput("done_pulse", 32'(fetch_done), 32'd1);
        checkOutput("req_drop", 32'(mem_req), 32'd0);
        checkOutput("req_cycles", 32'(reqCycles), 32'(waits + 1));
        checkOutput("pc_after", 32'(pc), 32'(expPc));
        checkOutput("err_low", 32'(fetch_err), 32'd0);
        en_fetch = extraStrobe;
        tick;
        en_fetch = 1'b0;
        inst_en  = '0;
        checkOutput("done_single", 32'(fetch_done), 32'd0);
        checkOutput("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic clearMidFetch;
        inst_en  = 6'b110000;
        en_fetch = 1'b1;
        tick;
        en_fetch = 1'b0;
        tick;
        clr = 1'b1;
        tick;
        clr       = 1'b0;
        expPc     = '0;
        expIr     = '0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        checkOutput("clr_req", 32'(mem_req), 32'd0);
        tick;
        mem_ack = 1'b0;
        inst_en = '0;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_done", 32'(fetch_done), 32'd0);
        checkOutput("clr_pc", 32'(pc), 32'd0);
        tick;
        checkOutput("clr_done2", 32'(fetch_done), 32'd0);
        checkFields;
    endtask

    task automatic noAckTest;
        logic [7:0] pcBefore;
        pcBefore = expPc;
        inst_en  = 6'b110000;
        en_fetch = 1'b1;
        tick;
        en_fetch = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int c = 1; c <= 15; c++) begin
            checkOutput("to_wait_req", 32'(mem_req), 32'd1);
            checkOutput("to_wait_done", 32'(fetch_done), 32'd0);
            tick;
        end
        checkOutput("to_wait_req", 32'(mem_req), 32'd1);
        tick;
        expIr = '0;
        checkOutput("to_done", 32'(fetch_done), 32'd1);
        checkOutput("to_err", 32'(fetch_err), 32'd1);
        checkOutput("to_pc", 32'(pc), 32'(pcBefore));
        tick;
        inst_en = '0;
        checkOutput("to_err_single", 32'(fetch_err), 32'd0);
        checkOutput("to_idle", 32'(busy), 32'd0);
        checkFields;
`else
        for (int c = 0; c < 100; c++) begin
            checkOutput("hold_req", 32'(mem_req), 32'd1);
            checkOutput("hold_err", 32'(fetch_err), 32'd0);
            tick;
        end
        checkOutput("hold_pc", 32'(pc), 32'(pcBefore));
        applyReset;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset;
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(fetch_done), 32'd0);
        checkOutput("rst_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_op", 32'(op_q), 32'd0);
        checkOutput("rst_x", 32'(x_sel), 32'd0);
        checkOutput("rst_y", 32'(y_sel), 32'd0);
        checkOutput("rst_addrq", 32'(addr_q), 32'd0);

        applyStimulus(2'b11, 3, 16'hA5C3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("pc_first", 32'(pc), 32'd1);
        checkFields;
        checkOutput("op_a5c3", 32'(op_q), 32'd5);
        checkOutput("x_a5c3", 32'(x_sel), 32'd1);
        checkOutput("y_a5c3", 32'(y_sel), 32'd1);
        checkOutput("addr_a5c3", 32'(addr_q), 32'hC3);

        idleJump(8'hFF);
        applyStimulus(2'b10, 1, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("pc_wrap", 32'(pc), 32'd0);
        applyStimulus(2'b10, 0, 16'h1234, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
        checkOutput("pc_load_wins", 32'(pc), 32'h40);

        applyStimulus(2'b11, 4, 16'h3C5A, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        checkFields;

        clearMidFetch;

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) idleJump(8'($urandom));
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 5), 16'($urandom),
                          ($urandom_range(0, 3) == 0), 8'($urandom),
                          ($urandom_range(0, 4) == 0), 8'($urandom),
                          1'($urandom_range(0, 1)));
            checkFields;
        end

        noAckTest;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
